// File: rtl/op_output_router_pkg.sv
// Shared types and helpers for the op output router: command codes, handler
// indices, servo levels and the router handshake state encoding.
package OpOutputRouter_PKG;

    localparam int OP_CMD_BITS = 4;

    // Op command encoding (Op_st.cmd)
    typedef enum logic [OP_CMD_BITS-1:0] {
        CMD_G00 = 4'd0,
        CMD_G01 = 4'd1,
        CMD_G02 = 4'd2,
        CMD_G03 = 4'd3,
        CMD_G04 = 4'd4,
        CMD_G20 = 4'd5,
        CMD_G21 = 4'd6,
        CMD_G28 = 4'd7,
        CMD_G90 = 4'd8,
        CMD_G91 = 4'd9,
        CMD_M03 = 4'd10,
        CMD_M05 = 4'd11
    } op_cmd_e;

    localparam logic SERVO_POS_UP = 1'b1;

    localparam int STEPPER_PULSE_NUM_X_BITS = 16;
    localparam int STEPPER_PULSE_NUM_Y_BITS = 16;

    localparam int unsigned HANDLER_LIN   = 0;
    localparam int unsigned HANDLER_CIRC  = 1;
    localparam int unsigned HANDLER_DUMMY = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ROUTE    = 2'd1,
        ST_WAIT_UPD = 2'd2
    } OpOutputRouter_state_e;

    // Linear moves go to the lin handler, arcs to circ, everything else to the
    // last (catch-all) handler. Indices beyond the handler count collapse onto it.
    function automatic int unsigned cmd_to_handler(input logic [OP_CMD_BITS-1:0] cmd,
                                                   input int unsigned num_handlers);
        int unsigned idx;
        case (cmd)
            CMD_G00, CMD_G01: idx = HANDLER_LIN;
            CMD_G02, CMD_G03: idx = HANDLER_CIRC;
            default:          idx = num_handlers - 1;
        endcase
        if (idx >= num_handlers) idx = num_handlers - 1;
        return idx;
    endfunction

endpackage

// File: rtl/op_output_router_mux.sv
// Combinational slice-select of every handler output field by handler index.
module op_handler_mux
    import OpOutputRouter_PKG::*;
#(
    parameter int NUM_HANDLERS = 3,
    parameter int X_BITS       = 16,
    parameter int Y_BITS       = 16,
    parameter int POS_BITS     = 16,
    parameter int SEL_W        = 2
) (
    input  logic [SEL_W-1:0]                       sel_i,
    input  logic [NUM_HANDLERS-1:0][X_BITS-1:0]    h_pulse_num_x_i,
    input  logic [NUM_HANDLERS-1:0][Y_BITS-1:0]    h_pulse_num_y_i,
    input  logic [NUM_HANDLERS-1:0]                h_servo_pos_i,
    input  logic [NUM_HANDLERS-1:0][POS_BITS-1:0]  h_new_x_i,
    input  logic [NUM_HANDLERS-1:0][POS_BITS-1:0]  h_new_y_i,
    output logic [X_BITS-1:0]                      pulse_num_x_o,
    output logic [Y_BITS-1:0]                      pulse_num_y_o,
    output logic                                   servo_pos_o,
    output logic [POS_BITS-1:0]                    new_x_o,
    output logic [POS_BITS-1:0]                    new_y_o
);

    always_comb begin
        pulse_num_x_o = '0;
        pulse_num_y_o = '0;
        servo_pos_o   = SERVO_POS_UP;
        new_x_o       = '0;
        new_y_o       = '0;
        for (int i = 0; i < NUM_HANDLERS; i++) begin
            if (sel_i == SEL_W'(i)) begin
                pulse_num_x_o = h_pulse_num_x_i[i];
                pulse_num_y_o = h_pulse_num_y_i[i];
                servo_pos_o   = h_servo_pos_i[i];
                new_x_o       = h_new_x_i[i];
                new_y_o       = h_new_y_i[i];
            end
        end
    end

endmodule

// File: rtl/op_output_router.sv
// Registered router: latches the handler chosen by the op command and forwards
// its motor/position outputs through a route / wait-for-update handshake.
module op_output_router
    import OpOutputRouter_PKG::*;
#(
    parameter int NUM_HANDLERS     = 3,
    parameter int PULSE_NUM_X_BITS = STEPPER_PULSE_NUM_X_BITS,
    parameter int PULSE_NUM_Y_BITS = STEPPER_PULSE_NUM_Y_BITS,
    parameter int POS_BITS         = 16,
    parameter int TIMEOUT_CYCLES   = 2**24
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          op_valid,
    input  logic [OP_CMD_BITS-1:0]                        op_cmd,
    output logic                                          op_ready,
    input  logic [NUM_HANDLERS-1:0][PULSE_NUM_X_BITS-1:0] h_pulse_num_x,
    input  logic [NUM_HANDLERS-1:0][PULSE_NUM_Y_BITS-1:0] h_pulse_num_y,
    input  logic [NUM_HANDLERS-1:0]                       h_servo_pos,
    input  logic [NUM_HANDLERS-1:0]                       h_trigger,
    input  logic [NUM_HANDLERS-1:0][POS_BITS-1:0]         h_new_x,
    input  logic [NUM_HANDLERS-1:0][POS_BITS-1:0]         h_new_y,
    input  logic [NUM_HANDLERS-1:0]                       h_update,
    output logic [PULSE_NUM_X_BITS-1:0]                   pulse_num_x,
    output logic [PULSE_NUM_Y_BITS-1:0]                   pulse_num_y,
    output logic                                          servo_pos,
    output logic                                          trigger,
    output logic [POS_BITS-1:0]                           new_x,
    output logic [POS_BITS-1:0]                           new_y,
    output logic                                          update,
    output logic [$clog2(NUM_HANDLERS)-1:0]               sel,
    output logic                                          stray_err,
    output logic                                          timeout_err,
    input  logic                                          err_clear
);

    localparam int SEL_W = $clog2(NUM_HANDLERS);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    OpOutputRouter_state_e state_q, state_d;
    logic [SEL_W-1:0]            sel_q, sel_d;
    logic [PULSE_NUM_X_BITS-1:0] px_q, px_d;
    logic [PULSE_NUM_Y_BITS-1:0] py_q, py_d;
    logic                        servo_q, servo_d;
    logic                        trig_q, trig_d;
    logic [POS_BITS-1:0]         nx_q, nx_d;
    logic [POS_BITS-1:0]         ny_q, ny_d;
    logic                        upd_q, upd_d;
    logic                        stray_q, stray_d;
    logic                        tmo_q, tmo_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic [PULSE_NUM_X_BITS-1:0] mux_px;
    logic [PULSE_NUM_Y_BITS-1:0] mux_py;
    logic                        mux_servo;
    logic [POS_BITS-1:0]         mux_nx, mux_ny;

    logic [NUM_HANDLERS-1:0] sel_oh;
    logic                    trig_sel, upd_sel, stray_set, tmo_hit;

    op_handler_mux #(
        .NUM_HANDLERS (NUM_HANDLERS),
        .X_BITS       (PULSE_NUM_X_BITS),
        .Y_BITS       (PULSE_NUM_Y_BITS),
        .POS_BITS     (POS_BITS),
        .SEL_W        (SEL_W)
    ) u_mux (
        .sel_i           (sel_q),
        .h_pulse_num_x_i (h_pulse_num_x),
        .h_pulse_num_y_i (h_pulse_num_y),
        .h_servo_pos_i   (h_servo_pos),
        .h_new_x_i       (h_new_x),
        .h_new_y_i       (h_new_y),
        .pulse_num_x_o   (mux_px),
        .pulse_num_y_o   (mux_py),
        .servo_pos_o     (mux_servo),
        .new_x_o         (mux_nx),
        .new_y_o         (mux_ny)
    );

    // Only the latched handler's strobes count; in IDLE nobody owns the path.
    assign sel_oh    = NUM_HANDLERS'(1) << sel_q;
    assign trig_sel  = |(h_trigger & sel_oh);
    assign upd_sel   = |(h_update & sel_oh);
    assign stray_set = (state_q == ST_IDLE) ? |(h_trigger | h_update)
                                            : |((h_trigger | h_update) & ~sel_oh);
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (state_q != ST_IDLE) && (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        px_d    = px_q;
        py_d    = py_q;
        servo_d = servo_q;
        trig_d  = 1'b0;
        nx_d    = nx_q;
        ny_d    = ny_q;
        upd_d   = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    sel_d   = SEL_W'(cmd_to_handler(op_cmd, NUM_HANDLERS));
                    cnt_d   = '0;
                    state_d = ST_ROUTE;
                end
            end
            ST_ROUTE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    px_d    = mux_px;
                    py_d    = mux_py;
                    servo_d = mux_servo;
                    trig_d  = trig_sel;
                    if (trig_sel) state_d = ST_WAIT_UPD;
                    // Zero-motion ops (and trigger+update together) finish here
                    if (upd_sel) begin
                        nx_d    = mux_nx;
                        ny_d    = mux_ny;
                        upd_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_UPD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else if (upd_sel) begin
                    nx_d    = mux_nx;
                    ny_d    = mux_ny;
                    upd_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new error event outranks a simultaneous clear
        stray_d = stray_set | (stray_q & ~err_clear);
        tmo_d   = tmo_hit | (tmo_q & ~err_clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            servo_q <= SERVO_POS_UP;
            trig_q  <= 1'b0;
            nx_q    <= '0;
            ny_q    <= '0;
            upd_q   <= 1'b0;
            stray_q <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            px_q    <= px_d;
            py_q    <= py_d;
            servo_q <= servo_d;
            trig_q  <= trig_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            upd_q   <= upd_d;
            stray_q <= stray_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign op_ready    = (state_q == ST_IDLE);
    assign sel         = sel_q;
    assign pulse_num_x = px_q;
    assign pulse_num_y = py_q;
    assign servo_pos   = servo_q;
    assign trigger     = trig_q;
    assign new_x       = nx_q;
    assign new_y       = ny_q;
    assign update      = upd_q;
    assign stray_err   = stray_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_op_output_router.sv
// Directed bench for op_output_router with a per-cycle behavioural model.
module tb_op_output_router;
    import OpOutputRouter_PKG::*;

    localparam int NH = 3, XW = 16, YW = 16, PW = 16, TMO = 16;

    logic clk = 1'b0, reset_n = 1'b0;
    always #5 clk = ~clk;

    logic op_valid, op_ready, err_clear;
    logic [OP_CMD_BITS-1:0] op_cmd;
    logic [NH-1:0][XW-1:0] hpx;
    logic [NH-1:0][YW-1:0] hpy;
    logic [NH-1:0][PW-1:0] hnx, hny;
    logic [NH-1:0] hsv, htr, hup;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [PW-1:0] nx, ny;
    logic sv, trig, upd, stray, tmo;
    logic [1:0] sel;

    // second instance: four handlers, idle handler inputs
    logic op_valid4, ready4, sv4, trig4, upd4, stray4, tmo4;
    logic [OP_CMD_BITS-1:0] op_cmd4;
    logic [3:0][XW-1:0] z4x;
    logic [3:0][YW-1:0] z4y;
    logic [3:0][PW-1:0] z4p;
    logic [3:0] z4b;
    logic [XW-1:0] px4;
    logic [YW-1:0] py4;
    logic [PW-1:0] nx4, ny4;
    logic [1:0] sel4;

    op_output_router #(.NUM_HANDLERS(NH), .PULSE_NUM_X_BITS(XW), .PULSE_NUM_Y_BITS(YW),
                       .POS_BITS(PW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_cmd(op_cmd), .op_ready(op_ready),
        .h_pulse_num_x(hpx), .h_pulse_num_y(hpy), .h_servo_pos(hsv), .h_trigger(htr),
        .h_new_x(hnx), .h_new_y(hny), .h_update(hup),
        .pulse_num_x(px), .pulse_num_y(py), .servo_pos(sv), .trigger(trig),
        .new_x(nx), .new_y(ny), .update(upd), .sel(sel),
        .stray_err(stray), .timeout_err(tmo), .err_clear(err_clear));

    op_output_router #(.NUM_HANDLERS(4), .PULSE_NUM_X_BITS(XW), .PULSE_NUM_Y_BITS(YW),
                       .POS_BITS(PW), .TIMEOUT_CYCLES(TMO)) dut4 (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid4), .op_cmd(op_cmd4), .op_ready(ready4),
        .h_pulse_num_x(z4x), .h_pulse_num_y(z4y), .h_servo_pos(z4b), .h_trigger(z4b),
        .h_new_x(z4p), .h_new_y(z4p), .h_update(z4b),
        .pulse_num_x(px4), .pulse_num_y(py4), .servo_pos(sv4), .trigger(trig4),
        .new_x(nx4), .new_y(ny4), .update(upd4), .sel(sel4),
        .stray_err(stray4), .timeout_err(tmo4), .err_clear(1'b0));

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // G00/G01 are lines, G02/G03 arcs, anything else goes to the last handler
    function automatic int exp_handler(input int cmd, input int nh);
        if (cmd == 0 || cmd == 1) return 0;
        if (cmd == 2 || cmd == 3) return 1;
        return nh - 1;
    endfunction

    // Op-level model: busy/waiting flags, owner index and op age in cycles
    bit m_busy, m_wait;
    int m_sel, m_age;
    logic [XW-1:0] e_px;
    logic [YW-1:0] e_py;
    logic [PW-1:0] e_nx, e_ny;
    logic e_sv, e_tr, e_up, e_stray, e_tmo;

    always @(posedge clk or negedge reset_n) begin : model
        bit s, t;
        if (!reset_n) begin
            m_busy = 0; m_wait = 0; m_sel = 0; m_age = 0;
            e_px = '0; e_py = '0; e_nx = '0; e_ny = '0;
            e_sv = 1'b1; e_tr = 0; e_up = 0; e_stray = 0; e_tmo = 0;
        end else begin
            s = 0;
            for (int i = 0; i < NH; i++)
                if ((htr[i] || hup[i]) && (!m_busy || i != m_sel)) s = 1;
            t = m_busy && (m_age == TMO - 1);
            e_tr = 0; e_up = 0;
            if (!m_busy) begin
                if (op_valid) begin
                    m_busy = 1; m_wait = 0; m_age = 0;
                    m_sel = exp_handler(int'(op_cmd), NH);
                end
            end else if (t) begin
                m_busy = 0;
            end else begin
                m_age++;
                if (!m_wait) begin
                    e_px = hpx[m_sel]; e_py = hpy[m_sel]; e_sv = hsv[m_sel];
                    e_tr = htr[m_sel]; m_wait = htr[m_sel];
                end
                if (hup[m_sel]) begin
                    e_nx = hnx[m_sel]; e_ny = hny[m_sel]; e_up = 1; m_busy = 0;
                end
            end
            e_stray = s || (e_stray && !err_clear);
            e_tmo   = t || (e_tmo && !err_clear);
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("m_ready", op_ready, !m_busy);
            chk("m_sel", sel, m_sel);
            chk("m_px", px, e_px);
            chk("m_py", py, e_py);
            chk("m_servo", sv, e_sv);
            chk("m_trig", trig, e_tr);
            chk("m_nx", nx, e_nx);
            chk("m_ny", ny, e_ny);
            chk("m_upd", upd, e_up);
            chk("m_stray", stray, e_stray);
            chk("m_tmo", tmo, e_tmo);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: no finish after 100000 time units");
        $fatal(1);
    end

    initial begin
        int cyc;
        op_valid = 0; op_cmd = '0; err_clear = 0;
        hpx = '0; hpy = '0; hnx = '0; hny = '0; hsv = '1; htr = '0; hup = '0;
        op_valid4 = 0; op_cmd4 = '0; z4x = '0; z4y = '0; z4p = '0; z4b = '0;
        reset_n = 0;
        repeat (2) step();
        chk("rst_ready", op_ready, 1);
        chk("rst_sel", sel, 0);
        chk("rst_servo", sv, 1);
        chk("rst_trig", trig, 0);
        chk("rst_stray", stray, 0);
        chk("rst_tmo", tmo, 0);
        reset_n = 1;
        step();

        // G01: trigger then update on handler 0
        op_valid = 1; op_cmd = CMD_G01; step(); op_valid = 0;
        chk("g01_sel", sel, 0);
        chk("g01_busy", op_ready, 0);
        hpx[0] = 16'd5; htr[0] = 1; step(); htr = '0; hpx[0] = 16'd7;
        chk("g01_trig", trig, 1);
        chk("g01_px", px, 5);
        step();
        chk("g01_trig_pulse", trig, 0);
        chk("g01_px_hold", px, 5);
        hnx[0] = 16'd100; hup[0] = 1; step(); hup = '0;
        chk("g01_upd", upd, 1);
        chk("g01_nx", nx, 100);
        step();
        chk("g01_upd_pulse", upd, 0);
        chk("g01_ready", op_ready, 1);

        // G02: strays from handlers 0 and 2, clear, clear vs fresh stray
        op_valid = 1; op_cmd = CMD_G02; step(); op_valid = 0;
        chk("g02_sel", sel, 1);
        htr[0] = 1; hup[2] = 1; step(); htr = '0; hup = '0;
        chk("stray_set", stray, 1);
        chk("stray_no_trig", trig, 0);
        chk("stray_no_upd", upd, 0);
        err_clear = 1; step(); err_clear = 0;
        chk("stray_clr", stray, 0);
        err_clear = 1; htr[0] = 1; step(); err_clear = 0; htr = '0;
        chk("stray_set_wins", stray, 1);
        err_clear = 1; step(); err_clear = 0;
        hnx[1] = 16'h0abc; hup[1] = 1; step(); hup = '0;
        chk("g02_upd", upd, 1);
        chk("g02_nx", nx, 16'h0abc);

        // G90: zero-motion update, then trigger+update together
        op_valid = 1; op_cmd = CMD_G90; step(); op_valid = 0;
        chk("g90_sel", sel, 2);
        hnx[2] = 16'h1234; hny[2] = 16'h0055; hup[2] = 1; step(); hup = '0;
        chk("g90_upd", upd, 1);
        chk("g90_nx", nx, 16'h1234);
        chk("g90_ny", ny, 16'h0055);
        chk("g90_ready", op_ready, 1);
        op_valid = 1; op_cmd = CMD_G90; step(); op_valid = 0;
        hpx[2] = 16'd9; hnx[2] = 16'h0042; htr[2] = 1; hup[2] = 1; step(); htr = '0; hup = '0;
        chk("g90tu_trig", trig, 1);
        chk("g90tu_upd", upd, 1);
        chk("g90tu_px", px, 9);
        chk("g90tu_nx", nx, 16'h0042);
        chk("g90tu_ready", op_ready, 1);

        // G00 triggered, never updated; G03 offered mid-op is ignored
        op_valid = 1; op_cmd = CMD_G00; step(); op_valid = 0;
        cyc = 0;
        while (tmo !== 1'b1 && cyc < 40) begin
            if (cyc == 0) htr[0] = 1;
            if (cyc == 1) begin op_valid = 1; op_cmd = CMD_G03; end
            step(); htr = '0; op_valid = 0; cyc++;
            if (cyc == 2) begin
                chk("ign_sel", sel, 0);
                chk("ign_busy", op_ready, 0);
            end
        end
        chk("tmo_cycles", cyc, TMO);
        chk("tmo_flag", tmo, 1);
        chk("tmo_ready", op_ready, 1);
        chk("tmo_trig", trig, 0);
        err_clear = 1; step(); err_clear = 0;
        chk("tmo_clr", tmo, 0);

        // Async reset while waiting for the update
        op_valid = 1; op_cmd = CMD_G01; step(); op_valid = 0;
        hpx[0] = 16'h0077; hsv[0] = 0; htr[0] = 1; hup[1] = 1; step(); htr = '0; hup = '0;
        chk("pre_rst_servo", sv, 0);
        chk("pre_rst_px", px, 16'h0077);
        chk("pre_rst_stray", stray, 1);
        #2 reset_n = 0;
        #1;
        chk("arst_px", px, 0);
        chk("arst_servo", sv, 1);
        chk("arst_stray", stray, 0);
        chk("arst_ready", op_ready, 1);
        chk("arst_nx", nx, 0);
        step(); reset_n = 1;
        step();

        // Four handlers: unknown command lands on the last one
        op_valid4 = 1; op_cmd4 = CMD_G91; step(); op_valid4 = 0;
        chk("nh4_sel", sel4, 3);
        chk("nh4_busy", ready4, 0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
